para_sync_fifo_fwft: RTL and testbench

//  Parametrised single-clock FIFO, next generation of the team's para sync FIFO.

---
 rtl/para_sync_fifo_fwft_if.sv | 45 ++++
 rtl/para_sync_fifo_fwft.sv | 162 ++++++++++++++++
 tb/tb_para_sync_fifo_fwft.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/para_sync_fifo_fwft_if.sv
// Port bundle for para_sync_fifo_fwft: write side, read side, thresholds, status and error flags.
// Latency: none, wiring only.
// Backpressure: producer watches full/prog_full, consumer watches valid/empty; the FIFO drops and flags illegal ops.
interface para_sync_fifo_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    // write side
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    // read side
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    // occupancy status
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  prog_full;
    logic                  prog_empty;
    logic [CNT_WIDTH-1:0]  prog_full_thr;
    logic [CNT_WIDTH-1:0]  prog_empty_thr;
    logic [CNT_WIDTH-1:0]  data_count;
    // sticky errors
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    // FIFO side
    modport slave (
        input  wr_en, din, rd_en, prog_full_thr, prog_empty_thr, clr_err,
        output dout, valid, full, empty, almost_full, almost_empty,
               prog_full, prog_empty, data_count, overflow, underflow
    );

    // producer/consumer side
    modport master (
        output wr_en, din, rd_en, prog_full_thr, prog_empty_thr, clr_err,
        input  dout, valid, full, empty, almost_full, almost_empty,
               prog_full, prog_empty, data_count, overflow, underflow
    );
endinterface

// File: rtl/para_sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable thresholds and sticky errors.
// Latency: standard mode dout/valid one edge after an accepted rd_en; FWFT head on dout one edge after its write.
// Backpressure: writes while full / reads while empty are dropped and set sticky flags; all flags are registered.
module para_sync_fifo_fwft #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int FWFT_MODE      = 0,
    parameter int PROG_FULL_DEF  = 50,
    parameter int PROG_EMPTY_DEF = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    para_sync_fifo_fwft_if.slave    fifo_if
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    // The documented threshold defaults must fit the threshold ports.
    if (PROG_FULL_DEF < 0 || PROG_FULL_DEF >= 2 ** CNT_WIDTH ||
        PROG_EMPTY_DEF < 0 || PROG_EMPTY_DEF >= 2 ** CNT_WIDTH) begin : g_bad_thr_default
        $error("para_sync_fifo_fwft: threshold default does not fit CNT_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  pfull_q, pfull_d;
    logic                  pempty_q, pempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] head_word;

    // Acceptance uses registered flags only, so no rd/wr-to-flag combinational path exists.
    assign wr_acc = fifo_if.wr_en && !full_q;
    assign rd_acc = fifo_if.rd_en && !empty_q;

    // Next-state pointers, occupancy, read data and flags derived from post-operation occupancy.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        head_word = '0;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        if (FWFT_MODE != 0) begin
            // The new head is the word being written this edge when nothing older remains.
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                head_word = fifo_if.din;
            end else begin
                head_word = mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
            end
            valid_d = (count_d != '0);
            if (valid_d) begin
                dout_d = head_word;
            end
        end else begin
            valid_d = rd_acc;
            if (rd_acc) begin
                dout_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end

        full_d   = (count_d == CNT_WIDTH'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_WIDTH'(DEPTH - 1));
        aempty_d = (count_d <= CNT_WIDTH'(1));
        pfull_d  = (count_d >= fifo_if.prog_full_thr);
        pempty_d = (count_d <= fifo_if.prog_empty_thr);

        // A fresh error event takes priority over clr_err.
        if (fifo_if.wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (fifo_if.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (fifo_if.rd_en && empty_q) begin
            unf_d = 1'b1;
        end else if (fifo_if.clr_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            pfull_q  <= 1'b0;
            pempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            pfull_q  <= pfull_d;
            pempty_q <= pempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_if.din;
        end
    end

    assign fifo_if.dout         = dout_q;
    assign fifo_if.valid        = valid_q;
    assign fifo_if.full         = full_q;
    assign fifo_if.empty        = empty_q;
    assign fifo_if.almost_full  = afull_q;
    assign fifo_if.almost_empty = aempty_q;
    assign fifo_if.prog_full    = pfull_q;
    assign fifo_if.prog_empty   = pempty_q;
    assign fifo_if.data_count   = count_q;
    assign fifo_if.overflow     = ovf_q;
    assign fifo_if.underflow    = unf_q;
endmodule

// File: tb/tb_para_sync_fifo_fwft.sv
// Bench for para_sync_fifo_fwft: one standard-mode and one FWFT-mode instance driven with identical traffic.
// Latency: reference model is a queue; expected read words are queued at issue and popped by output monitors.
// Backpressure: model decides acceptance from its own occupancy; DUT flags are compared after every edge.
module tb_para_sync_fifo_fwft;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW:0]   pft = 7'd50;
    logic [AW:0]   pet = 7'd10;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_std_q[$];
    logic [DW-1:0] exp_fwft_q[$];
    bit            ovf_m = 1'b0;
    bit            unf_m = 1'b0;
    bit            std_vld_m = 1'b0;

    always #5 clk = ~clk;

    para_sync_fifo_fwft_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
    para_sync_fifo_fwft_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

    assign s_if.wr_en = wr_en;          assign f_if.wr_en = wr_en;
    assign s_if.rd_en = rd_en;          assign f_if.rd_en = rd_en;
    assign s_if.din = din;              assign f_if.din = din;
    assign s_if.clr_err = clr_err;      assign f_if.clr_err = clr_err;
    assign s_if.prog_full_thr = pft;    assign f_if.prog_full_thr = pft;
    assign s_if.prog_empty_thr = pet;   assign f_if.prog_empty_thr = pet;

    para_sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT_MODE(0),
                          .PROG_FULL_DEF(50), .PROG_EMPTY_DEF(10))
        u_std (.clk(clk), .rst(rst), .fifo_if(s_if));

    para_sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT_MODE(1),
                          .PROG_FULL_DEF(50), .PROG_EMPTY_DEF(10))
        u_fwft (.clk(clk), .rst(rst), .fifo_if(f_if));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output word with no expected entry at %0t", name, $time);
    endtask

    // Standard-mode monitor: every valid pulse consumes one expected word.
    always @(negedge clk) begin
        if (!rst && s_if.valid) begin
            if (exp_std_q.size() == 0) chk_unexpected("std.dout");
            else chk("std.dout", 32'(s_if.dout), 32'(exp_std_q.pop_front()));
        end
    end

    // FWFT monitor: the presented word is checked at the moment it is popped.
    always @(negedge clk) begin
        if (!rst && f_if.valid && rd_en) begin
            if (exp_fwft_q.size() == 0) chk_unexpected("fwft.dout");
            else chk("fwft.dout", 32'(f_if.dout), 32'(exp_fwft_q.pop_front()));
        end
    end

    task automatic chk_flags(input string p, input logic [AW:0] cnt, input logic f, input logic e,
                             input logic af, input logic ae, input logic pf, input logic pe,
                             input logic ov, input logic un, input bit r);
        int n;
        n = model_q.size();
        chk({p, ".data_count"},   32'(cnt), 32'(n));
        chk({p, ".full"},         32'(f),   32'(n == DEPTH));
        chk({p, ".empty"},        32'(e),   32'(n == 0));
        chk({p, ".almost_full"},  32'(af),  32'(n >= DEPTH - 1));
        chk({p, ".almost_empty"}, 32'(ae),  32'(n <= 1));
        chk({p, ".prog_full"},    32'(pf),  32'(!r && n >= int'(pft)));
        chk({p, ".prog_empty"},   32'(pe),  32'(r || n <= int'(pet)));
        chk({p, ".overflow"},     32'(ov),  32'(ovf_m));
        chk({p, ".underflow"},    32'(un),  32'(unf_m));
    endtask

    // One clock of stimulus: update the model, let the edge happen, compare status.
    task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d, input bit clr, input bit r);
        int  n0;
        bit  wacc;
        bit  racc;
        wr_en = wr; rd_en = rd; din = d; clr_err = clr; rst = r;
        n0 = model_q.size();
        if (r) begin
            model_q.delete();
            ovf_m = 1'b0; unf_m = 1'b0; std_vld_m = 1'b0;
        end else begin
            wacc = wr && (n0 != DEPTH);
            racc = rd && (n0 != 0);
            if (racc) begin
                exp_std_q.push_back(model_q[0]);
                exp_fwft_q.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (wacc) model_q.push_back(d);
            if (wr && n0 == DEPTH) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
            if (rd && n0 == 0)     unf_m = 1'b1; else if (clr) unf_m = 1'b0;
            std_vld_m = racc;
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_std_q.delete();
            exp_fwft_q.delete();
            chk("std.dout_reset",  32'(s_if.dout), 32'd0);
            chk("fwft.dout_reset", 32'(f_if.dout), 32'd0);
        end
        chk_flags("std", s_if.data_count, s_if.full, s_if.empty, s_if.almost_full, s_if.almost_empty,
                  s_if.prog_full, s_if.prog_empty, s_if.overflow, s_if.underflow, r);
        chk_flags("fwft", f_if.data_count, f_if.full, f_if.empty, f_if.almost_full, f_if.almost_empty,
                  f_if.prog_full, f_if.prog_empty, f_if.overflow, f_if.underflow, r);
        chk("std.valid",  32'(s_if.valid), 32'(std_vld_m));
        chk("fwft.valid", 32'(f_if.valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) chk("fwft.head", 32'(f_if.dout), 32'(model_q[0]));
    endtask

    initial begin
        int pw;
        int pr;
        logic [DW-1:0] pat;

        // reset and idle
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);

        // fill with 0x00..0x3F, overflow attempts, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 0, 8'hEE, 0, 0);
        step(1, 1, 8'hDD, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        // underflow set, clear, and clear colliding with a new underflow
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 1, 0);
        step(1, 1, 8'h77, 1, 0);
        step(0, 1, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // 32 held, then 200 cycles of simultaneous read+write (pointer wrap)
        pat = 8'h00;
        for (int i = 0; i < 32; i++) begin step(1, 0, pat, 0, 0); pat++; end
        for (int i = 0; i < 200; i++) begin step(1, 1, pat, 0, 0); pat++; end
        for (int i = 0; i < 32; i++) step(0, 1, 8'h00, 0, 0);

        // single word into empty, then pop
        step(1, 0, 8'hA5, 0, 0);
        chk("fwft.a5_dout",  32'(f_if.dout), 32'h0000_00A5);
        chk("fwft.a5_valid", 32'(f_if.valid), 32'd1);
        step(0, 1, 8'h00, 0, 0);

        // thresholds: 0 forces prog_full, above DEPTH never asserts
        pft = 7'd0;  pet = 7'd0;
        step(0, 0, 8'h00, 0, 0);
        pft = 7'd65; pet = 7'd64;
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom), 0, 0);
        step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0, 0);
        pft = 7'd50; pet = 7'd10;

        // reset mid-stream at count 40, then restart from address 0
        for (int i = 0; i < 40; i++) step(1, 0, 8'(8'h80 + i), 0, 0);
        step(1, 1, 8'h55, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);

        // randomized traffic with shifting bias, error clears and threshold changes
        for (int blk = 0; blk < 16; blk++) begin
            case (blk % 4)
                0: begin pw = 80; pr = 20; end
                1: begin pw = 20; pr = 80; end
                2: begin pw = 50; pr = 50; end
                default: begin pw = 95; pr = 95; end
            endcase
            pft = 7'($urandom_range(70, 0));
            pet = 7'($urandom_range(70, 0));
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(99, 0) < pw, $urandom_range(99, 0) < pr, 8'($urandom),
                     $urandom_range(15, 0) == 0, (blk == 9) && (c == 100));
            end
        end

        step(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        #1;
        chk("std.scoreboard_left",  32'(exp_std_q.size()),  32'd0);
        chk("fwft.scoreboard_left", 32'(exp_fwft_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
